// File: rtl/qmf_analysis_decim_axis.sv
// Stereo two-band QMF analysis stage with decimation by 2.
// Full-band AXI-Stream in, low/high subband AXI-Streams out, prototype h0[] loaded over AXI-Lite.
module qmf_analysis_decim_axis #(
  parameter int NTAPS              = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [31:0]                   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [31:0]                   m_axis_low_tdata,
  output logic                          m_axis_low_tvalid,
  input  logic                          m_axis_low_tready,
  output logic                          m_axis_low_tlast,
  output logic [31:0]                   m_axis_high_tdata,
  output logic                          m_axis_high_tvalid,
  input  logic                          m_axis_high_tready,
  output logic                          m_axis_high_tlast,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
);
  localparam int AW = 32 + $clog2(NTAPS);
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

  logic en, clear_pulse, phase, last_sticky;
  logic signed [15:0] h0   [NTAPS];
  logic signed [15:0] dl_l [NTAPS];
  logic signed [15:0] dl_r [NTAPS];
  logic signed [15:0] nd_l [NTAPS];
  logic signed [15:0] nd_r [NTAPS];

  logic [IW-1:0] widx, ridx;
  logic wr_hs, waddr_ok, raddr_ok, unused_wdata;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;

  assign widx         = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ridx         = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign waddr_ok     = (s_axi_awaddr[1:0] == 2'b00);
  assign raddr_ok     = (s_axi_araddr[1:0] == 2'b00);
  assign wr_hs        = s_axi_awready && s_axi_awvalid && s_axi_wready && s_axi_wvalid;
  assign s_axi_bresp  = 2'b00;
  assign s_axi_rresp  = 2'b00;
  assign unused_wdata = ^s_axi_wdata[C_S_AXI_DATA_WIDTH-1:16];

  always_comb begin
    rd_mux = '0;
    if (raddr_ok) begin
      if (ridx == '0) rd_mux[0] = en;
      for (int n = 0; n < NTAPS; n++)
        if (ridx == IW'(n + 1)) rd_mux[15:0] = h0[n];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      en            <= 1'b0;
      clear_pulse   <= 1'b0;
      for (int n = 0; n < NTAPS; n++) h0[n] <= '0;
    end else begin
      s_axi_awready <= !s_axi_awready && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
      s_axi_wready  <= !s_axi_awready && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
      clear_pulse   <= 1'b0;
      if (wr_hs) s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      if (wr_hs && waddr_ok) begin
        if (widx == '0) begin
          en          <= s_axi_wdata[0];
          clear_pulse <= s_axi_wdata[1];
        end
        for (int n = 0; n < NTAPS; n++)
          if (widx == IW'(n + 1)) h0[n] <= s_axi_wdata[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
    end else if (!s_axi_arready && s_axi_arvalid && !s_axi_rvalid) begin
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b1;
      s_axi_rdata   <= rd_mux;
    end else begin
      s_axi_arready <= 1'b0;
      if (s_axi_rvalid && s_axi_rready) s_axi_rvalid <= 1'b0;
    end
  end

  // Post-shift view of the delay line: outputs are computed from it on phase-1 beats.
  always_comb begin
    nd_l[0] = s_axis_tdata[15:0];
    nd_r[0] = s_axis_tdata[31:16];
    for (int n = 1; n < NTAPS; n++) begin
      nd_l[n] = dl_l[n-1];
      nd_r[n] = dl_r[n-1];
    end
  end

  function automatic logic signed [AW-1:0] sext(input logic signed [31:0] p);
    sext = {{(AW-32){p[31]}}, p};
  endfunction

  function automatic logic [15:0] sat16(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = a >>> 15;
    if ((&s[AW-1:15]) || !(|s[AW-1:15])) sat16 = s[15:0];
    else if (s[AW-1])                    sat16 = 16'h8000;
    else                                 sat16 = 16'h7fff;
  endfunction

  logic signed [AW-1:0] acc_lo_l, acc_hi_l, acc_lo_r, acc_hi_r;
  logic signed [31:0]   p_l, p_r;

  always_comb begin
    acc_lo_l = '0;
    acc_hi_l = '0;
    acc_lo_r = '0;
    acc_hi_r = '0;
    p_l      = '0;
    p_r      = '0;
    for (int n = 0; n < NTAPS; n++) begin
      p_l      = 32'(h0[n]) * 32'(nd_l[n]);
      p_r      = 32'(h0[n]) * 32'(nd_r[n]);
      acc_lo_l = acc_lo_l + sext(p_l);
      acc_lo_r = acc_lo_r + sext(p_r);
      if (n % 2 == 0) begin
        acc_hi_l = acc_hi_l + sext(p_l);
        acc_hi_r = acc_hi_r + sext(p_r);
      end else begin
        acc_hi_l = acc_hi_l - sext(p_l);
        acc_hi_r = acc_hi_r - sext(p_r);
      end
    end
  end

  logic low_free, high_free, accept, last_out;
  assign low_free      = !m_axis_low_tvalid || m_axis_low_tready;
  assign high_free     = !m_axis_high_tvalid || m_axis_high_tready;
  assign s_axis_tready = en && !clear_pulse && (!phase || (low_free && high_free));
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign last_out      = last_sticky | s_axis_tlast;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase              <= 1'b0;
      last_sticky        <= 1'b0;
      m_axis_low_tvalid  <= 1'b0;
      m_axis_low_tdata   <= '0;
      m_axis_low_tlast   <= 1'b0;
      m_axis_high_tvalid <= 1'b0;
      m_axis_high_tdata  <= '0;
      m_axis_high_tlast  <= 1'b0;
      for (int n = 0; n < NTAPS; n++) begin
        dl_l[n] <= '0;
        dl_r[n] <= '0;
      end
    end else begin
      if (m_axis_low_tvalid && m_axis_low_tready)   m_axis_low_tvalid  <= 1'b0;
      if (m_axis_high_tvalid && m_axis_high_tready) m_axis_high_tvalid <= 1'b0;
      if (clear_pulse) begin
        phase       <= 1'b0;
        last_sticky <= 1'b0;
        for (int n = 0; n < NTAPS; n++) begin
          dl_l[n] <= '0;
          dl_r[n] <= '0;
        end
      end else if (accept) begin
        phase <= !phase;
        for (int n = 0; n < NTAPS; n++) begin
          dl_l[n] <= nd_l[n];
          dl_r[n] <= nd_r[n];
        end
        if (!phase) begin
          last_sticky <= last_out;
        end else begin
          last_sticky        <= 1'b0;
          m_axis_low_tvalid  <= 1'b1;
          m_axis_low_tdata   <= {sat16(acc_lo_r), sat16(acc_lo_l)};
          m_axis_low_tlast   <= last_out;
          m_axis_high_tvalid <= 1'b1;
          m_axis_high_tdata  <= {sat16(acc_hi_r), sat16(acc_hi_l)};
          m_axis_high_tlast  <= last_out;
        end
      end
    end
  end
endmodule
